// File: rtl/usb_ep_buf_mc.sv
// Multi-endpoint IN packet buffer: per-EP ring of committed banks, filled by user logic and
// drained by the link layer; a bank is only released once the host has acknowledged it.
module usb_ep_buf_mc #(
    parameter int unsigned NUM_EP   = 4,
    parameter int unsigned EP_W     = 2,
    parameter int unsigned NUM_BANK = 2,
    parameter int unsigned BANK_W   = 1,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned DATA_W   = 8
) (
    input  logic              local_clk,
    input  logic              reset,
    input  logic [EP_W-1:0]   buf_in_ep,
    input  logic [ADDR_W-1:0] buf_in_addr,
    input  logic [DATA_W-1:0] buf_in_data,
    input  logic              buf_in_wren,
    input  logic              buf_in_commit,
    input  logic [ADDR_W:0]   buf_in_commit_len,
    output logic [NUM_EP-1:0] buf_in_ready,
    output logic              buf_in_commit_ack,
    output logic              err_commit_full,
    input  logic [EP_W-1:0]   lnk_ep,
    input  logic [ADDR_W-1:0] lnk_addr,
    output logic [DATA_W-1:0] lnk_q,
    output logic [ADDR_W:0]   lnk_len,
    output logic [NUM_EP-1:0] lnk_hasdata,
    input  logic              lnk_done,
    input  logic              lnk_flush
);

    localparam int unsigned MemAw    = EP_W + BANK_W + ADDR_W;
    localparam int unsigned MemDepth = 2 ** MemAw;

    localparam logic [BANK_W:0]   CntFull = (BANK_W + 1)'(NUM_BANK);
    localparam logic [BANK_W:0]   CntOne  = (BANK_W + 1)'(1);
    localparam logic [BANK_W-1:0] PtrOne  = BANK_W'(1);
    localparam logic [ADDR_W:0]   MaxLen  = (ADDR_W + 1)'(2 ** ADDR_W);

    logic [DATA_W-1:0] mem [MemDepth];

    logic [BANK_W-1:0] wr_ptr_q [NUM_EP];
    logic [BANK_W-1:0] wr_ptr_d [NUM_EP];
    logic [BANK_W-1:0] rd_ptr_q [NUM_EP];
    logic [BANK_W-1:0] rd_ptr_d [NUM_EP];
    logic [BANK_W:0]   cnt_q    [NUM_EP];
    logic [BANK_W:0]   cnt_d    [NUM_EP];
    logic [ADDR_W:0]   len_q    [NUM_EP][NUM_BANK];
    logic [ADDR_W:0]   len_d    [NUM_EP][NUM_BANK];

    logic              ack_q;
    logic              err_q;
    logic [DATA_W-1:0] lnk_q_q;

    logic              flush_hits_commit;
    logic              commit_ok;
    logic              commit_err;
    logic              done_ok;
    logic              wr_en;
    logic [ADDR_W:0]   commit_len_sat;
    logic [MemAw-1:0]  wr_addr;
    logic [MemAw-1:0]  rd_addr;
    logic [NUM_EP-1:0] commit_hit;
    logic [NUM_EP-1:0] done_hit;
    logic [NUM_EP-1:0] flush_hit;

    // Status flags come straight from the registered bank counts.
    always_comb begin
        buf_in_ready = '0;
        lnk_hasdata  = '0;
        for (int e = 0; e < NUM_EP; e++) begin
            buf_in_ready[e] = (cnt_q[e] != CntFull);
            lnk_hasdata[e]  = (cnt_q[e] != '0);
        end
    end

    // A flush to the committing EP swallows the commit entirely: no ack, no error.
    assign flush_hits_commit = lnk_flush && (lnk_ep == buf_in_ep);
    assign commit_ok  = buf_in_commit && buf_in_ready[buf_in_ep] && !flush_hits_commit;
    assign commit_err = buf_in_commit && !buf_in_ready[buf_in_ep] && !flush_hits_commit;
    assign done_ok    = lnk_done && lnk_hasdata[lnk_ep] && !lnk_flush;
    assign wr_en      = buf_in_wren && buf_in_ready[buf_in_ep];

    assign commit_len_sat = (buf_in_commit_len > MaxLen) ? MaxLen : buf_in_commit_len;

    assign wr_addr = {buf_in_ep, wr_ptr_q[buf_in_ep], buf_in_addr};
    assign rd_addr = {lnk_ep, rd_ptr_q[lnk_ep], lnk_addr};

    always_comb begin
        commit_hit = '0;
        done_hit   = '0;
        flush_hit  = '0;
        for (int e = 0; e < NUM_EP; e++) begin
            commit_hit[e] = commit_ok && (buf_in_ep == EP_W'(e));
            done_hit[e]   = done_ok && (lnk_ep == EP_W'(e));
            flush_hit[e]  = lnk_flush && (lnk_ep == EP_W'(e));
        end
    end

    always_comb begin
        for (int e = 0; e < NUM_EP; e++) begin
            wr_ptr_d[e] = wr_ptr_q[e];
            rd_ptr_d[e] = rd_ptr_q[e];
            cnt_d[e]    = cnt_q[e];
            for (int b = 0; b < NUM_BANK; b++) begin
                len_d[e][b] = len_q[e][b];
            end

            if (commit_hit[e]) begin
                len_d[e][wr_ptr_q[e]] = commit_len_sat;
                wr_ptr_d[e]           = wr_ptr_q[e] + PtrOne;
            end
            if (done_hit[e]) begin
                rd_ptr_d[e] = rd_ptr_q[e] + PtrOne;
            end

            // Concurrent commit and release leave the occupancy unchanged.
            if (commit_hit[e] && !done_hit[e]) begin
                cnt_d[e] = cnt_q[e] + CntOne;
            end else if (done_hit[e] && !commit_hit[e]) begin
                cnt_d[e] = cnt_q[e] - CntOne;
            end

            if (flush_hit[e]) begin
                wr_ptr_d[e] = '0;
                rd_ptr_d[e] = '0;
                cnt_d[e]    = '0;
            end
        end
    end

    always_ff @(posedge local_clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < NUM_EP; e++) begin
                wr_ptr_q[e] <= '0;
                rd_ptr_q[e] <= '0;
                cnt_q[e]    <= '0;
                for (int b = 0; b < NUM_BANK; b++) begin
                    len_q[e][b] <= '0;
                end
            end
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            lnk_q_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            ack_q    <= commit_ok;
            err_q    <= commit_err;
            lnk_q_q  <= mem[rd_addr];
        end
    end

    // Packet storage is deliberately left out of reset.
    always_ff @(posedge local_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= buf_in_data;
        end
    end

    assign buf_in_commit_ack = ack_q;
    assign err_commit_full   = err_q;
    assign lnk_q             = lnk_q_q;
    assign lnk_len           = len_q[lnk_ep][rd_ptr_q[lnk_ep]];

endmodule

// File: tb/tb_usb_ep_buf_mc.sv
// Bench for usb_ep_buf_mc: directed scenarios plus a randomized run checked against per-endpoint
// packet queues holding length, data tag and number of words written.
module tb_usb_ep_buf_mc;

    logic       local_clk = 1'b0;
    logic       reset;
    logic [1:0] buf_in_ep;
    logic [8:0] buf_in_addr;
    logic [7:0] buf_in_data;
    logic       buf_in_wren;
    logic       buf_in_commit;
    logic [9:0] buf_in_commit_len;
    logic [3:0] buf_in_ready;
    logic       buf_in_commit_ack;
    logic       err_commit_full;
    logic [1:0] lnk_ep;
    logic [8:0] lnk_addr;
    logic [7:0] lnk_q;
    logic [9:0] lnk_len;
    logic [3:0] lnk_hasdata;
    logic       lnk_done;
    logic       lnk_flush;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: FIFO of packets per endpoint, at most two deep.
    int q_len [4][$];
    int q_tag [4][$];
    int q_nw  [4][$];

    usb_ep_buf_mc dut (
        .local_clk         (local_clk),
        .reset             (reset),
        .buf_in_ep         (buf_in_ep),
        .buf_in_addr       (buf_in_addr),
        .buf_in_data       (buf_in_data),
        .buf_in_wren       (buf_in_wren),
        .buf_in_commit     (buf_in_commit),
        .buf_in_commit_len (buf_in_commit_len),
        .buf_in_ready      (buf_in_ready),
        .buf_in_commit_ack (buf_in_commit_ack),
        .err_commit_full   (err_commit_full),
        .lnk_ep            (lnk_ep),
        .lnk_addr          (lnk_addr),
        .lnk_q             (lnk_q),
        .lnk_len           (lnk_len),
        .lnk_hasdata       (lnk_hasdata),
        .lnk_done          (lnk_done),
        .lnk_flush         (lnk_flush)
    );

    always #5 local_clk = ~local_clk;

    function automatic logic [7:0] pat(input int tag, input int a);
        return 8'(tag ^ a);
    endfunction

    function automatic logic [3:0] exp_ready();
        logic [3:0] r;
        for (int e = 0; e < 4; e++) r[e] = (q_len[e].size() < 2);
        return r;
    endfunction

    function automatic logic [3:0] exp_hasdata();
        logic [3:0] r;
        for (int e = 0; e < 4; e++) r[e] = (q_len[e].size() != 0);
        return r;
    endfunction

    task automatic step();
        @(negedge local_clk);
    endtask

    task automatic fill(input int e, input int tag, input int n);
        for (int a = 0; a < n; a++) begin
            buf_in_ep   = 2'(e);
            buf_in_addr = 9'(a);
            buf_in_data = pat(tag, a);
            buf_in_wren = 1'b1;
            step();
        end
        buf_in_wren = 1'b0;
    endtask

    // Commit to e, optionally with a concurrent done on d; judges ack/err from model pre-state.
    task automatic commit(input int e, input int len, input int tag, input int nw,
                          input int d, input bit dd);
        bit acc;
        bit dn;
        acc = (q_len[e].size() < 2);
        dn  = dd && (q_len[d].size() != 0);
        buf_in_ep         = 2'(e);
        buf_in_commit     = 1'b1;
        buf_in_commit_len = 10'(len);
        lnk_ep            = 2'(d);
        lnk_done          = dd;
        step();
        buf_in_commit = 1'b0;
        lnk_done      = 1'b0;
        if (acc) begin
            q_len[e].push_back(len > 512 ? 512 : len);
            q_tag[e].push_back(tag);
            q_nw[e].push_back(nw);
        end
        if (dn) begin
            void'(q_len[d].pop_front());
            void'(q_tag[d].pop_front());
            void'(q_nw[d].pop_front());
        end
        n_tests++;
        if (buf_in_commit_ack !== acc) begin
            n_fail++;
            $display("FAIL commit_ack ep%0d: got %0b, expected %0b", e, buf_in_commit_ack, acc);
        end
        n_tests++;
        if (err_commit_full !== !acc) begin
            n_fail++;
            $display("FAIL commit_err ep%0d: got %0b, expected %0b", e, err_commit_full, !acc);
        end
        step();
        n_tests++;
        if ({buf_in_commit_ack, err_commit_full} !== 2'b00) begin
            n_fail++;
            $display("FAIL pulse_width ep%0d: got %02b, expected 00", e,
                     {buf_in_commit_ack, err_commit_full});
        end
    endtask

    task automatic do_done(input int e);
        lnk_ep   = 2'(e);
        lnk_done = 1'b1;
        step();
        lnk_done = 1'b0;
        if (q_len[e].size() != 0) begin
            void'(q_len[e].pop_front());
            void'(q_tag[e].pop_front());
            void'(q_nw[e].pop_front());
        end
    endtask

    // Flush e, optionally with a commit to c in the same cycle.
    task automatic flush(input int e, input bit wc, input int c);
        bit acc;
        bit rej;
        acc = wc && (c != e) && (q_len[c].size() < 2);
        rej = wc && (c != e) && (q_len[c].size() >= 2);
        lnk_ep            = 2'(e);
        lnk_flush         = 1'b1;
        buf_in_ep         = 2'(c);
        buf_in_commit     = wc;
        buf_in_commit_len = 10'd3;
        step();
        lnk_flush     = 1'b0;
        buf_in_commit = 1'b0;
        q_len[e].delete();
        q_tag[e].delete();
        q_nw[e].delete();
        if (acc) begin
            q_len[c].push_back(3);
            q_tag[c].push_back(0);
            q_nw[c].push_back(0);
        end
        n_tests++;
        if ({buf_in_commit_ack, err_commit_full} !== {acc, rej}) begin
            n_fail++;
            $display("FAIL flush_ack_err ep%0d: got %02b, expected %02b", e,
                     {buf_in_commit_ack, err_commit_full}, {acc, rej});
        end
        step();
    endtask

    task automatic read_chk(input int e, input int a);
        logic [7:0] exp;
        exp      = pat(q_tag[e][0], a);
        lnk_ep   = 2'(e);
        lnk_addr = 9'(a);
        step();
        n_tests++;
        if (lnk_q !== exp) begin
            n_fail++;
            $display("FAIL read ep%0d addr%0d: got %02h, expected %02h", e, a, lnk_q, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        buf_in_ep = '0; buf_in_addr = '0; buf_in_data = '0; buf_in_wren = 1'b0;
        buf_in_commit = 1'b0; buf_in_commit_len = '0;
        lnk_ep = '0; lnk_addr = '0; lnk_done = 1'b0; lnk_flush = 1'b0;
        repeat (3) step();
        n_tests++;
        if (lnk_q !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_lnk_q: got %02h, expected 00", lnk_q);
        end
        reset = 1'b0;
        step();
        n_tests++;
        if (buf_in_ready !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_ready: got %h, expected f", buf_in_ready);
        end
        n_tests++;
        if (lnk_hasdata !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_hasdata: got %h, expected 0", lnk_hasdata);
        end
        n_tests++;
        if ({buf_in_commit_ack, err_commit_full} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_pulses: got %02b, expected 00",
                     {buf_in_commit_ack, err_commit_full});
        end
    endtask

    task automatic test_single_packet();
        fill(0, 0, 64);
        commit(0, 64, 0, 64, 0, 1'b0);
        lnk_ep = 2'd0;
        #1;
        n_tests++;
        if (lnk_hasdata[0] !== 1'b1 || lnk_len !== 10'd64) begin
            n_fail++;
            $display("FAIL t1_status: got hasdata=%0b len=%0d, expected 1/64",
                     lnk_hasdata[0], lnk_len);
        end
        read_chk(0, 5);
        read_chk(0, 63);
    endtask

    task automatic test_full_err();
        fill(1, 8'h11, 4);
        commit(1, 10, 8'h11, 4, 1, 1'b0);
        fill(1, 8'h22, 4);
        commit(1, 20, 8'h22, 4, 1, 1'b0);
        n_tests++;
        if (buf_in_ready[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL t2_full_ready: got %0b, expected 0", buf_in_ready[1]);
        end
        commit(1, 5, 8'h33, 0, 1, 1'b0);
        do_done(1);
        n_tests++;
        if (lnk_len !== 10'd20 || buf_in_ready[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL t2_after_done: got len=%0d ready=%0b, expected 20/1",
                     lnk_len, buf_in_ready[1]);
        end
        read_chk(1, 3);
    endtask

    task automatic test_retry();
        logic [7:0] first [8];
        fill(2, 8'hA5, 8);
        commit(2, 8, 8'hA5, 8, 2, 1'b0);
        for (int a = 0; a < 8; a++) begin
            read_chk(2, a);
            first[a] = lnk_q;
        end
        for (int a = 0; a < 8; a++) begin
            lnk_addr = 9'(a);
            step();
            n_tests++;
            if (lnk_q !== first[a] || lnk_q !== pat(8'hA5, a)) begin
                n_fail++;
                $display("FAIL t3_retry addr%0d: got %02h, expected %02h", a, lnk_q,
                         pat(8'hA5, a));
            end
        end
        do_done(2);
        n_tests++;
        if (lnk_hasdata[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_hasdata: got %0b, expected 0", lnk_hasdata[2]);
        end
    endtask

    task automatic test_commit_done();
        fill(3, 8'h31, 2);
        commit(3, 7, 8'h31, 2, 3, 1'b0);
        fill(3, 8'h32, 2);
        commit(3, 9, 8'h32, 2, 3, 1'b0);
        commit(3, 11, 8'h33, 0, 3, 1'b1);
        n_tests++;
        if (lnk_hasdata[3] !== 1'b1 || buf_in_ready[3] !== 1'b1 || lnk_len !== 10'd9) begin
            n_fail++;
            $display("FAIL t4_full_cd: got hd=%0b rdy=%0b len=%0d, expected 1/1/9",
                     lnk_hasdata[3], buf_in_ready[3], lnk_len);
        end
        fill(3, 8'h34, 3);
        commit(3, 13, 8'h34, 3, 3, 1'b1);
        n_tests++;
        if (lnk_hasdata[3] !== 1'b1 || buf_in_ready[3] !== 1'b1 || lnk_len !== 10'd13) begin
            n_fail++;
            $display("FAIL t4_one_cd: got hd=%0b rdy=%0b len=%0d, expected 1/1/13",
                     lnk_hasdata[3], buf_in_ready[3], lnk_len);
        end
        read_chk(3, 2);
    endtask

    task automatic test_len_clamp();
        flush(1, 1'b0, 0);
        commit(1, 0, 0, 0, 1, 1'b0);
        n_tests++;
        if (lnk_len !== 10'd0 || lnk_hasdata[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_zlp: got len=%0d hd=%0b, expected 0/1", lnk_len, lnk_hasdata[1]);
        end
        do_done(1);
        commit(1, 600, 0, 0, 1, 1'b0);
        n_tests++;
        if (lnk_len !== 10'd512) begin
            n_fail++;
            $display("FAIL t5_clamp: got %0d, expected 512", lnk_len);
        end
        do_done(1);
    endtask

    task automatic test_flush();
        fill(0, 8'h40, 2);
        commit(0, 2, 8'h40, 2, 0, 1'b0);
        n_tests++;
        if (buf_in_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_two_queued: got ready=%0b, expected 0", buf_in_ready[0]);
        end
        flush(0, 1'b1, 0);
        n_tests++;
        if (lnk_hasdata !== exp_hasdata() || buf_in_ready !== exp_ready()) begin
            n_fail++;
            $display("FAIL t6_flush: got hd=%h rdy=%h, expected %h/%h", lnk_hasdata,
                     buf_in_ready, exp_hasdata(), exp_ready());
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            int op;
            int e;
            int d;
            op = $urandom_range(0, 5);
            e  = $urandom_range(0, 3);
            d  = $urandom_range(0, 3);
            case (op)
                0, 1: begin
                    int n;
                    int tag;
                    int len;
                    bit dd;
                    n   = $urandom_range(0, 12);
                    tag = $urandom_range(0, 255);
                    len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : n;
                    dd  = ($urandom_range(0, 2) == 0);
                    fill(e, tag, n);
                    commit(e, len, tag, n, d, dd);
                end
                2: do_done(e);
                3: begin
                    if (q_len[e].size() != 0 && q_nw[e][0] != 0) begin
                        read_chk(e, $urandom_range(0, q_nw[e][0] - 1));
                    end
                end
                4: flush(e, 1'($urandom_range(0, 1)), d);
                default: begin
                    // With every bank queued the fill bank aliases the oldest packet.
                    if (q_len[e].size() == 2) begin
                        buf_in_ep   = 2'(e);
                        buf_in_addr = 9'd0;
                        buf_in_data = 8'h5C;
                        buf_in_wren = 1'b1;
                        step();
                        buf_in_wren = 1'b0;
                        if (q_nw[e][0] != 0) read_chk(e, 0);
                    end
                end
            endcase
            n_tests++;
            if (buf_in_ready !== exp_ready() || lnk_hasdata !== exp_hasdata()) begin
                n_fail++;
                $display("FAIL rnd_flags it%0d: got rdy=%h hd=%h, expected %h/%h", it,
                         buf_in_ready, lnk_hasdata, exp_ready(), exp_hasdata());
            end
            if (q_len[e].size() != 0) begin
                lnk_ep = 2'(e);
                #1;
                n_tests++;
                if (lnk_len !== 10'(q_len[e][0])) begin
                    n_fail++;
                    $display("FAIL rnd_len it%0d ep%0d: got %0d, expected %0d", it, e,
                             lnk_len, q_len[e][0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        flush(2, 1'b0, 0);
        fill(2, 8'h5A, 4);
        commit(2, 4, 8'h5A, 4, 2, 1'b0);
        read_chk(2, 1);
        buf_in_ep   = 2'd2;
        buf_in_addr = 9'd7;
        buf_in_data = 8'hEE;
        buf_in_wren = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (buf_in_ready !== 4'hF || lnk_hasdata !== 4'h0 || lnk_q !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset: got rdy=%h hd=%h q=%02h, expected f/0/00",
                     buf_in_ready, lnk_hasdata, lnk_q);
        end
        buf_in_wren = 1'b0;
        for (int e = 0; e < 4; e++) begin
            q_len[e].delete();
            q_tag[e].delete();
            q_nw[e].delete();
        end
        repeat (2) step();
        reset = 1'b0;
        step();
        fill(2, 8'h66, 3);
        commit(2, 3, 8'h66, 3, 2, 1'b0);
        read_chk(2, 2);
        n_tests++;
        if (lnk_hasdata !== 4'b0100) begin
            n_fail++;
            $display("FAIL post_reset_hd: got %h, expected 4", lnk_hasdata);
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_full_err();
        test_retry();
        test_commit_done();
        test_len_clamp();
        test_flush();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
